// File: rtl/led_event_ctrl.sv
// Per-channel LED controller: decoded key events drive an independent
// OFF / ON / BLINK / FLASH state machine per channel.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_OFF   | LED dark
//   ST_ON    | LED lit
//   ST_BLINK | LED toggles every BLINK_HALF cycles, starts lit
//   ST_FLASH | LED inverted for PULSE_LEN cycles, then returns to ret
module led_event_ctrl #(
  parameter int N_CH       = 3,
  parameter int BLINK_HALF = 25_000_000,
  parameter int PULSE_LEN  = 10_000_000
) (
  input  logic                CLOCK,
  input  logic                RST,
  input  logic [N_CH-1:0]     Evt_S,
  input  logic [N_CH-1:0]     Evt_L,
  input  logic [N_CH-1:0]     Evt_D,
  output logic [N_CH-1:0]     LED,
  output logic [2*N_CH-1:0]   Mode
);

  localparam int CNT_MAX = (BLINK_HALF > PULSE_LEN) ? BLINK_HALF : PULSE_LEN;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] PULSE_TC = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_ON    = 2'b01;
  localparam logic [1:0] ST_BLINK = 2'b10;
  localparam logic [1:0] ST_FLASH = 2'b11;

  logic [N_CH-1:0][1:0]    st, st_nx;
  logic [N_CH-1:0][1:0]    ret, ret_nx;
  logic [N_CH-1:0][CW-1:0] cnt, cnt_nx;
  logic [N_CH-1:0]         led_q, led_nx;

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      st    <= '0;
      ret   <= '0;
      cnt   <= '0;
      led_q <= '0;
    end else begin
      st    <= st_nx;
      ret   <= ret_nx;
      cnt   <= cnt_nx;
      led_q <= led_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    ret_nx = ret;
    cnt_nx = cnt;
    led_nx = led_q;
    for (int i = 0; i < N_CH; i++) begin
      case (st[i])
        // Only a long click is honoured while flashing; it restarts the pulse.
        ST_FLASH: begin
          if (Evt_L[i]) begin
            cnt_nx[i] = '0;
          end else if (cnt[i] == PULSE_TC) begin
            st_nx[i]  = ret[i];
            cnt_nx[i] = '0;
            led_nx[i] = (ret[i] != ST_OFF);
          end else begin
            cnt_nx[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          if (Evt_L[i]) begin
            st_nx[i]  = ST_FLASH;
            ret_nx[i] = st[i];
            cnt_nx[i] = '0;
            led_nx[i] = ~led_q[i];
          end else if (Evt_D[i]) begin
            st_nx[i]  = (st[i] == ST_BLINK) ? ST_ON : ST_BLINK;
            cnt_nx[i] = '0;
            led_nx[i] = 1'b1;
          end else if (Evt_S[i]) begin
            st_nx[i]  = (st[i] == ST_OFF) ? ST_ON : ST_OFF;
            cnt_nx[i] = '0;
            led_nx[i] = (st[i] == ST_OFF);
          end else if (st[i] == ST_BLINK) begin
            if (cnt[i] == BLINK_TC) begin
              cnt_nx[i] = '0;
              led_nx[i] = ~led_q[i];
            end else begin
              cnt_nx[i] = cnt[i] + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    LED  = led_q;
    Mode = '0;
    for (int i = 0; i < N_CH; i++) begin
      Mode[2*i +: 2] = st[i];
    end
  end

endmodule
